// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use stall; 1-cycle latency.
// Backpressure: stall is asserted combinationally for one cycle on a load-use hazard and a bubble is loaded.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_alusrc1,
    input  logic          id_alusrc2,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic [RW-1:0] id_wr_addr,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_wr_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_wr_addr,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_fun,
    output logic          alu_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wr_addr,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs_addr;
        logic [RW-1:0] rt_addr;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic          alusrc1;
        logic          alusrc2;
        logic [5:0]    alufun;
        logic          sign;
        logic [RW-1:0] wr_addr;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } ex_t;

    ex_t ex_d;
    ex_t ex_q;

    logic          uses_rs;
    logic          uses_rt;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Store instructions read rt as data even when operand B is the immediate.
    always_comb begin
        uses_rs = !id_alusrc1;
        uses_rt = !id_alusrc2 || id_mem_write;
        stall   = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.wr_addr != '0)
                  && ((uses_rs && (ex_q.wr_addr == id_rs_addr))
                   || (uses_rt && (ex_q.wr_addr == id_rt_addr)))
                  && !flush;
    end

    always_comb begin
        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid     = id_valid;
            ex_d.rs_addr   = id_rs_addr;
            ex_d.rt_addr   = id_rt_addr;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = id_imm;
            ex_d.shamt     = id_shamt;
            ex_d.alusrc1   = id_alusrc1;
            ex_d.alusrc2   = id_alusrc2;
            ex_d.alufun    = id_alufun;
            ex_d.sign      = id_sign;
            ex_d.wr_addr   = id_wr_addr;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // The younger EX/MEM result wins over MEM/WB; r0 is hardwired and never forwarded.
    always_comb begin
        if (exmem_reg_write && (exmem_wr_addr != '0) && (exmem_wr_addr == ex_q.rs_addr)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_wr_addr != '0) && (memwb_wr_addr == ex_q.rs_addr)) begin
            fwd_rs = memwb_result;
        end else begin
            fwd_rs = ex_q.rs_data;
        end

        if (exmem_reg_write && (exmem_wr_addr != '0) && (exmem_wr_addr == ex_q.rt_addr)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_wr_addr != '0) && (memwb_wr_addr == ex_q.rt_addr)) begin
            fwd_rt = memwb_result;
        end else begin
            fwd_rt = ex_q.rt_data;
        end
    end

    always_comb begin
        ex_valid      = ex_q.valid;
        alu_a         = ex_q.alusrc1 ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
        alu_b         = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
        alu_fun       = ex_q.alufun;
        alu_sign      = ex_q.sign;
        ex_store_data = fwd_rt;
        ex_wr_addr    = ex_q.wr_addr;
        ex_reg_write  = ex_q.reg_write && ex_q.valid;
        ex_mem_read   = ex_q.mem_read && ex_q.valid;
        ex_mem_write  = ex_q.mem_write && ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of the instruction held in EX.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc1, id_alusrc2, id_sign, id_reg_write, id_mem_read, id_mem_write;
    logic [5:0]  id_alufun;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_wr_addr, memwb_wr_addr;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid, alu_sign, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_fun;
    logic [4:0]  ex_wr_addr;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_wr_addr(id_wr_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_wr_addr(exmem_wr_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_wr_addr(memwb_wr_addr), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_fun(alu_fun), .alu_sign(alu_sign), .ex_store_data(ex_store_data),
        .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, wr, shamt;
        logic [31:0] rsd, rtd, imm;
        logic        a1, a2, sign, rw, mr, mw;
        logic [5:0]  fun;
    } inst_t;

    inst_t m;
    int    err_cnt = 0;
    int    chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value of register a as seen by EX, given the in-flight writers.
    function automatic logic [31:0] reg_val(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return rf;
        if (exmem_reg_write && exmem_wr_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_wr_addr == a) return memwb_result;
        return rf;
    endfunction

    // A valid load in EX whose destination is read by the valid ID instruction must wait a cycle.
    function automatic logic hazard();
        logic reads_rs, reads_rt;
        reads_rs = !id_alusrc1 && id_rs_addr == m.wr;
        reads_rt = (!id_alusrc2 || id_mem_write) && id_rt_addr == m.wr;
        return !flush && id_valid && m.valid && m.mr && m.wr != 0 && (reads_rs || reads_rt);
    endfunction

    task automatic cyc();
        inst_t nxt;
        #1;
        check_eq("stall", stall, hazard());
        check_eq("ex_valid", ex_valid, m.valid);
        check_eq("alu_a", alu_a, m.a1 ? {27'd0, m.shamt} : reg_val(m.rs, m.rsd));
        check_eq("alu_b", alu_b, m.a2 ? m.imm : reg_val(m.rt, m.rtd));
        check_eq("store_data", ex_store_data, reg_val(m.rt, m.rtd));
        check_eq("alu_fun", alu_fun, m.fun);
        check_eq("alu_sign", alu_sign, m.sign);
        check_eq("wr_addr", ex_wr_addr, m.wr);
        check_eq("reg_write", ex_reg_write, m.valid && m.rw);
        check_eq("mem_read", ex_mem_read, m.valid && m.mr);
        check_eq("mem_write", ex_mem_write, m.valid && m.mw);
        nxt = '{default: '0};
        if (!reset && !flush && !hazard()) begin
            nxt.valid = id_valid;   nxt.rs = id_rs_addr;    nxt.rt = id_rt_addr;
            nxt.rsd = id_rs_data;   nxt.rtd = id_rt_data;   nxt.imm = id_imm;
            nxt.shamt = id_shamt;   nxt.a1 = id_alusrc1;    nxt.a2 = id_alusrc2;
            nxt.fun = id_alufun;    nxt.sign = id_sign;     nxt.wr = id_wr_addr;
            nxt.rw = id_reg_write;  nxt.mr = id_mem_read;   nxt.mw = id_mem_write;
        end
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_alusrc1 = 0; id_alusrc2 = 0; id_alufun = 0;
        id_sign = 0; id_wr_addr = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0; exmem_reg_write = 0; exmem_wr_addr = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_wr_addr = 0; memwb_result = 0;
    endtask

    task automatic rnd_inputs();
        id_valid = ($urandom_range(0, 4) != 0);
        id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
        id_wr_addr = 5'($urandom_range(0, 3));
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom); id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom);
        id_alufun = 6'($urandom); id_sign = 1'($urandom); id_reg_write = 1'($urandom);
        id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 7) == 0);
        exmem_reg_write = 1'($urandom); exmem_wr_addr = 5'($urandom_range(0, 3)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_wr_addr = 5'($urandom_range(0, 3)); memwb_result = $urandom;
    endtask

    task automatic load_to(input logic [4:0] r);
        idle();
        cyc();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_wr_addr = r; id_alusrc2 = 1;
        cyc();
    endtask

    initial begin
        m = '{default: '0};
        idle();
        reset = 1;
        rnd_inputs();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Second reset cycle with random ID traffic: stage must stay empty.
        rnd_inputs();
        cyc();
        check_eq("rst_ex_valid", ex_valid, 0);
        check_eq("rst_reg_write", ex_reg_write, 0);
        check_eq("rst_alu_fun", alu_fun, 0);
        check_eq("rst_stall", stall, 0);
        reset = 0;

        idle();
        id_valid = 1; id_rs_addr = 10; id_rt_addr = 11; id_rs_data = 15; id_rt_data = 31;
        id_alufun = 6'b011010; id_sign = 1;
        cyc();
        check_eq("basic_a", alu_a, 15);
        check_eq("basic_b", alu_b, 31);
        check_eq("basic_fun", alu_fun, 6'b011010);
        check_eq("basic_sign", alu_sign, 1);

        idle();
        id_valid = 1; id_rs_addr = 8; id_rs_data = 32'h1111;
        cyc();
        exmem_reg_write = 1; exmem_wr_addr = 8; exmem_result = 32'hAAAA0000;
        memwb_reg_write = 1; memwb_wr_addr = 8; memwb_result = 32'h5555;
        #1 check_eq("fwd_exmem", alu_a, 32'hAAAA0000);
        exmem_reg_write = 0;
        #1 check_eq("fwd_memwb", alu_a, 32'h5555);
        exmem_reg_write = 1; exmem_wr_addr = 0; memwb_wr_addr = 0;
        #1 check_eq("fwd_addr0", alu_a, 32'h1111);

        load_to(9);
        idle();
        id_valid = 1; id_rs_addr = 9; id_rt_addr = 2; id_alufun = 6'h21; id_reg_write = 1; id_wr_addr = 4;
        #1 check_eq("lu_stall", stall, 1);
        cyc();
        check_eq("lu_bubble", ex_valid, 0);
        check_eq("lu_stall_drop", stall, 0);
        cyc();
        check_eq("lu_enter", ex_valid, 1);
        check_eq("lu_fun", alu_fun, 6'h21);

        load_to(9);
        idle();
        id_valid = 1; id_rs_addr = 9; id_rt_addr = 2; id_alusrc1 = 1; id_alusrc2 = 1;
        #1 check_eq("lu_shamt_nostall", stall, 0);
        cyc();

        load_to(9);
        idle();
        id_valid = 1; id_rs_addr = 9; id_reg_write = 1; id_wr_addr = 5; flush = 1;
        #1 check_eq("flush_stall", stall, 0);
        cyc();
        check_eq("flush_bubble", ex_valid, 0);
        check_eq("flush_reg_write", ex_reg_write, 0);

        idle();
        id_valid = 1; id_alusrc1 = 1; id_shamt = 5; id_alusrc2 = 1; id_imm = 32'hFFFFFFF0;
        id_rs_addr = 6; id_rs_data = 32'h66; id_rt_addr = 3; id_rt_data = 32'h77;
        cyc();
        check_eq("sh_a", alu_a, 5);
        check_eq("sh_b", alu_b, 32'hFFFFFFF0);
        check_eq("sh_store", ex_store_data, 32'h77);
        memwb_reg_write = 1; memwb_wr_addr = 3; memwb_result = 32'h99;
        #1 check_eq("sh_store_fwd", ex_store_data, 32'h99);
        cyc();

        for (int i = 0; i < 400; i++) begin
            rnd_inputs();
            reset = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
